fifo_uart_tx: RTL and testbench

Downstream drain stage for the synchronous flag-based FIFO. It pops one word at a time through the FIFO's rd/empty/d_out interface and transmits it LSB-first as a UART frame: start bit, DATA_WIDTH data bits, optional parity bit, stop bit. It sits between the FIFO and the chip's serial TX pin, giving buffered, back-to-back serial output.

---
 rtl/fifo_uart_pkg.sv | 28 ++
 rtl/fifo_uart_baud_gen.sv | 33 +++
 rtl/fifo_uart_tx.sv | 157 +++++++++++++++
 tb/tb_fifo_uart_tx.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg
// Shared definitions for the FIFO-draining UART transmitter:
//   - 3-bit FSM state encoding (IDLE..STOP)
//   - default bit period in clk cycles
// Optional macro used by importers: FIFO_UART_TX_PARITY_EN
package fifo_uart_pkg;

    localparam int DEF_CLKS_PER_BIT = 16;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_START  = 3'd3;
    localparam logic [2:0] S_DATA   = 3'd4;
    localparam logic [2:0] S_PARITY = 3'd5;
    localparam logic [2:0] S_STOP   = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_FETCH  = S_FETCH,
        ST_LOAD   = S_LOAD,
        ST_START  = S_START,
        ST_DATA   = S_DATA,
        ST_PARITY = S_PARITY,
        ST_STOP   = S_STOP
    } state_t;

endpackage

// File: rtl/fifo_uart_baud_gen.sv
// fifo_uart_baud_gen
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 and wraps; bit_done is high
// during the terminal-count cycle.
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   clear    hold the counter at 0 (no bit_done while asserted)
//   bit_done one-cycle pulse on the last cycle of each bit period
module fifo_uart_baud_gen
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int CNT_SIZE     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_done
);

    localparam logic [CNT_SIZE-1:0] TERM = CNT_SIZE'(CLKS_PER_BIT - 1);

    logic [CNT_SIZE-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear)     cnt <= '0;
        else if (cnt == TERM) cnt <= '0;
        else                  cnt <= cnt + 1'b1;
    end

    assign bit_done = !clear && (cnt == TERM);

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
// Pops words from a synchronous flag-based FIFO and sends each one as a
// UART frame, LSB first: start, DATA_WIDTH data bits, [parity], stop.
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   fifo_empty  FIFO empty flag
//   fifo_d_out  FIFO registered read data (valid the cycle after fifo_rd)
//   fifo_rd     registered one-cycle read strobe to the FIFO
//   tx          registered serial output, idles high
//   busy        high from the pop request until the end of the stop bit
// Macro: FIFO_UART_TX_PARITY_EN adds an even-parity bit after the data bits.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int CNT_SIZE     = 8,
    parameter int BIT_SIZE     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_d_out,
    output logic                  fifo_rd,
    output logic                  tx,
    output logic                  busy
);

    localparam logic [BIT_SIZE-1:0] LAST_IDX = BIT_SIZE'(DATA_WIDTH - 1);

    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] shift_q, shift_n;
    logic [BIT_SIZE-1:0]   idx_q, idx_n;
    logic                  stop_tail_q, stop_tail_n;
    logic                  fifo_rd_n, busy_n, tx_n;
    logic                  bit_done, baud_clr;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                  par_q, par_n;
`endif

    // Bit timing only runs while a frame is on the line.
    assign baud_clr = (state == ST_IDLE) || (state == ST_FETCH) || (state == ST_LOAD);

    fifo_uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .CNT_SIZE    (CNT_SIZE)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clear   (baud_clr),
        .bit_done(bit_done)
    );

    always_comb begin
        state_n     = state;
        shift_n     = shift_q;
        idx_n       = idx_q;
        stop_tail_n = stop_tail_q;
        fifo_rd_n   = 1'b0;
        busy_n      = busy;
        tx_n        = 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
        par_n       = par_q;
`endif
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_rd_n = 1'b1;
                    busy_n    = 1'b1;
                    state_n   = ST_FETCH;
                end
            end
            ST_FETCH: state_n = ST_LOAD;
            ST_LOAD: begin
                shift_n = fifo_d_out;
                idx_n   = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                par_n   = ^fifo_d_out;
`endif
                state_n = ST_START;
            end
            ST_START: begin
                tx_n = 1'b0;
                if (bit_done) state_n = ST_DATA;
            end
            ST_DATA: begin
                tx_n = shift_q[0];
                if (bit_done) begin
                    shift_n = shift_q >> 1;
                    if (idx_q == LAST_IDX) begin
                        idx_n = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                        state_n = ST_PARITY;
`else
                        state_n = ST_STOP;
`endif
                    end else begin
                        idx_n = idx_q + 1'b1;
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: begin
                tx_n = par_q;
                if (bit_done) state_n = ST_STOP;
            end
`endif
            ST_STOP: begin
                // tx is registered, so the line trails the state by one cycle.
                // STOP holds one tail cycle past its terminal count so the
                // busy drop / next pop lines up with the end of the stop bit
                // as seen on the pin.
                if (bit_done) stop_tail_n = 1'b1;
                if (stop_tail_q) begin
                    stop_tail_n = 1'b0;
                    busy_n      = 1'b0;
                    if (!fifo_empty) begin
                        fifo_rd_n = 1'b1;
                        busy_n    = 1'b1;
                        state_n   = ST_FETCH;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            shift_q     <= '0;
            idx_q       <= '0;
            stop_tail_q <= 1'b0;
            fifo_rd     <= 1'b0;
            busy        <= 1'b0;
            tx          <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            shift_q     <= shift_n;
            idx_q       <= idx_n;
            stop_tail_q <= stop_tail_n;
            fifo_rd     <= fifo_rd_n;
            busy        <= busy_n;
            tx          <= tx_n;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q       <= par_n;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx
// Bench for fifo_uart_tx with a queue-based FIFO in front of it and a
// frame-level model: after each pop, the line is start / data LSB first /
// [parity] / stop, each CLKS_PER_BIT wide, beginning 3 cycles after the pop
// edge, and the next pop may follow frame length + 3 cycles after the last.
// Honors FIFO_UART_TX_PARITY_EN.
module tb_fifo_uart_tx;

    localparam int DW = 8;
    localparam int C  = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NBITS = DW + 3;
`else
    localparam int NBITS = DW + 2;
`endif
    localparam int FRAME = NBITS * C;

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_d_out = '0;
    logic          fifo_rd, tx, busy;

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(C),
        .CNT_SIZE    (8),
        .BIT_SIZE    (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_empty(fifo_empty),
        .fifo_d_out(fifo_d_out),
        .fifo_rd   (fifo_rd),
        .tx        (tx),
        .busy      (busy)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- FIFO stand-in ----------------
    logic          wr      = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] fq[$];
    int            underflow = 0;

    always @(posedge clk) begin
        logic [DW-1:0] w;
        if (fifo_rd === 1'b1) begin
            if (fq.size() == 0) underflow <= underflow + 1;
            else begin
                w = fq.pop_front();
                fifo_d_out <= w;
            end
        end
        if (wr) fq.push_back(wr_data);
        fifo_empty <= (fq.size() == 0);
    end

    // ---------------- frame-level model ----------------
    logic          m_act  = 1'b0;
    int            m_k    = 0;     // edges since the pop edge
    logic [DW-1:0] m_word = '0;
    logic [DW-1:0] mq[$];

    always @(posedge clk) begin
        logic [DW-1:0] w;
        if (rst) begin
            m_act <= 1'b0;
            m_k   <= 0;
        end else if (!m_act || m_k == FRAME + 2) begin
            if (!fifo_empty && mq.size() > 0) begin
                w = mq.pop_front();
                m_act  <= 1'b1;
                m_k    <= 0;
                m_word <= w;
            end else begin
                m_act <= 1'b0;
            end
        end else begin
            m_k <= m_k + 1;
        end
        if (wr) mq.push_back(wr_data);
    end

    function automatic logic exp_tx(input logic act, input int k, input logic [DW-1:0] w);
        int b;
        if (!act || k < 3) return 1'b1;
        b = (k - 3) / C;
        if (b == 0) return 1'b0;
        if (b <= DW) return w[b-1];
        if (b == DW + 1 && NBITS == DW + 3) return ^w;
        return 1'b1;
    endfunction

    logic chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("tx", tx, exp_tx(m_act, m_k, m_word));
            check("busy", busy, m_act);
            check("fifo_rd", fifo_rd, m_act && (m_k == 0));
        end
    end

    // ---------------- tallies ----------------
    int cyc = 0, rd_tot = 0, busy_tot = 0;
    int rd_cyc[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd === 1'b1) begin
            rd_tot <= rd_tot + 1;
            rd_cyc.push_back(cyc);
        end
        if (busy === 1'b1) busy_tot <= busy_tot + 1;
    end

    // ---------------- helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [DW-1:0] d);
        wr = 1'b1; wr_data = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic wait_rd(input int lim);
        for (int i = 0; i < lim && fifo_rd !== 1'b1; i++) @(negedge clk);
        check("rd_seen", fifo_rd, 1'b1);
    endtask

    task automatic wait_idle(input int lim);
        for (int i = 0; i < lim && (busy !== 1'b0 || fifo_empty !== 1'b1); i++) @(negedge clk);
        check("idle_reached", busy, 1'b0);
    endtask

    // Call on the negedge where fifo_rd is high; samples mid-bit.
    task automatic capture(output logic [15:0] f);
        f = '0;
        tick(3 + C/2);
        f[0] = tx;
        for (int b = 1; b < NBITS; b++) begin
            tick(C);
            f[b] = tx;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [15:0] f;
        int r0, b0, q0, n;

        rst = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        tick(2);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_rd", fifo_rd, 1'b0);
        rst = 1'b0;

        r0 = rd_tot;
        tick(50);
        check("idle_no_rd", rd_tot - r0, 0);

        // single word
        r0 = rd_tot; b0 = busy_tot;
        push(8'hA5);
        wait_rd(10);
        capture(f);
        check("a5_start", f[0], 1'b0);
        check("a5_data", f[DW:1], 8'hA5);
        check("a5_stop", f[NBITS-1], 1'b1);
        wait_idle(30);
        tick(2);
        check("a5_busy_len", busy_tot - b0, 3 + FRAME);
        check("a5_rd_cnt", rd_tot - r0, 1);
        check("a5_empty", fifo_empty, 1'b1);

        // back-to-back
        r0 = rd_tot; q0 = rd_cyc.size();
        push(8'h01);
        push(8'h80);
        push(8'hFF);
        wait_idle(3 * (FRAME + 3) + 20);
        tick(2);
        check("b2b_rd_cnt", rd_tot - r0, 3);
        if (rd_cyc.size() >= q0 + 3) begin
            check("b2b_pitch1", rd_cyc[q0+1] - rd_cyc[q0], FRAME + 3);
            check("b2b_pitch2", rd_cyc[q0+2] - rd_cyc[q0+1], FRAME + 3);
        end

        // reset during the third data bit
        push(8'h3C);
        wait_rd(10);
        tick(3 + 3*C + 1);
        rst = 1'b1;
        tick(1);
        check("mr_tx", tx, 1'b1);
        check("mr_busy", busy, 1'b0);
        check("mr_rd", fifo_rd, 1'b0);
        rst = 1'b0;
        tick(5);
        check("mr_idle", busy, 1'b0);
        b0 = busy_tot;
        push(8'h5A);
        wait_rd(10);
        capture(f);
        check("mr_next_data", f[DW:1], 8'h5A);
        wait_idle(30);
        tick(2);
        check("mr_next_busy", busy_tot - b0, 3 + FRAME);

        // late fill after idle
        tick(10);
        push(8'h55);
        wait_rd(2);
        n = 0;
        while (tx !== 1'b0 && n < 10) begin
            tick(1);
            n++;
        end
        check("late_latency", n, 3);
        wait_idle(FRAME + 20);

`ifdef FIFO_UART_TX_PARITY_EN
        push(8'h07);
        wait_rd(10);
        capture(f);
        check("p07_data", f[DW:1], 8'h07);
        check("p07_par", f[DW+1], 1'b1);
        wait_idle(30);
        b0 = busy_tot;
        push(8'h03);
        wait_rd(10);
        capture(f);
        check("p03_par", f[DW+1], 1'b0);
        wait_idle(30);
        tick(2);
        check("p03_busy_len", busy_tot - b0, 47);
`endif

        tick(5);
        check("no_underflow", underflow, 0);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
